// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
// Holds the common FSM state encoding, line levels, parity selectors and default widths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_MIN = 2;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_PRESCALE_WIDTH = 6;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Parallel-side and serial-side signals of the UART transmitter.
// The master drives the byte request; the slave (serializer) drives the line and Busy.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Parity generator shared by the TX serializer and the RX parity checker.
// par_typ selects even (0) or odd (1) parity over the whole data word.
module uart_tx_parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    assign par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a byte on DATA_VALID and shifts it out LSB-first as
// start / data / optional parity / stop, each bit held for Prescale clock cycles.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_serializer_if.slave  tx_if
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0]          LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_WIDTH-1:0] PRESC_MIN = PRESCALE_WIDTH'(PRESCALE_MIN);

    uart_state_e               state_q,    state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [IDX_W-1:0]          bit_idx_q,  bit_idx_d;
    logic [DATA_WIDTH-1:0]     data_q,     data_d;
    logic                      par_en_q,   par_en_d;
    logic                      par_typ_q,  par_typ_d;
    logic [PRESCALE_WIDTH-1:0] presc_q,    presc_d;
    logic                      tx_q,       tx_d;
    logic                      busy_q,     busy_d;

    logic par_bit;
    logic bit_done;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_q),
        .par_typ (par_typ_q),
        .par_bit (par_bit)
    );

    assign bit_done = (edge_cnt_q == (presc_q - PRESCALE_WIDTH'(1)));

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        presc_d    = presc_q;

        if (state_q == IDLE) begin
            if (tx_if.DATA_VALID) begin
                data_d     = tx_if.P_DATA;
                par_en_d   = tx_if.PAR_EN;
                par_typ_d  = tx_if.PAR_TYP;
                // Prescale below 2 would collapse the bit counter; clamp it.
                presc_d    = (tx_if.Prescale < PRESC_MIN) ? PRESC_MIN : tx_if.Prescale;
                edge_cnt_d = '0;
                bit_idx_d  = '0;
                state_d    = START;
            end
        end else if (!bit_done) begin
            edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
        end else begin
            edge_cnt_d = '0;
            case (state_q)
                START:   state_d = DATA;
                DATA: begin
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so the line changes on the same edge.
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = data_d[bit_idx_d];
            PARITY:  tx_d = par_bit;
            default: tx_d = STOP_BIT;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            presc_q    <= PRESC_MIN;
            tx_q       <= STOP_BIT;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            presc_q    <= presc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: each accepted request queues its expected
// frame; a line monitor pops it when a start bit appears and checks every cycle.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       ptyp;
        int         p;
        int         k;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;
    exp_t sb_q[$];

    uart_tx_serializer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) tx_if ();

    uart_tx_serializer #(
        .DATA_WIDTH     (8),
        .PRESCALE_WIDTH (6)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (tx_if)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at the negedge where the start bit was first seen.
    task automatic check_frame(input exp_t e);
        logic bits [12];
        int   n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
        n = 9;
        if (e.pen) begin
            bits[n] = (^e.data) ^ e.ptyp;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        chk("start_cyc", cyc, e.k);
        for (int j = 0; j < n; j++) begin
            for (int c = 0; c < e.p; c++) begin
                if (!(j == 0 && c == 0)) @(negedge CLK);
                chk($sformatf("bit%0d_d%0h", j, e.data), tx_if.TX_OUT, bits[j]);
                chk("busy_hi", tx_if.Busy, 1'b1);
            end
        end
        @(negedge CLK);
        chk("end_tx", tx_if.TX_OUT, 1'b1);
        chk("end_busy", tx_if.Busy, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (mon_en && RST) begin
                if (tx_if.TX_OUT == 1'b0) begin
                    if (sb_q.size() == 0) begin
                        chk("spurious_start", tx_if.TX_OUT, 1'b1);
                    end else begin
                        mon_busy = 1'b1;
                        e = sb_q.pop_front();
                        check_frame(e);
                        mon_busy = 1'b0;
                    end
                end else if (sb_q.size() == 0) begin
                    chk("idle_busy", tx_if.Busy, 1'b0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pen, input logic typ,
                        input logic [5:0] ps, input bit track);
        exp_t e;
        @(negedge CLK);
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pen;
        tx_if.PAR_TYP    = typ;
        tx_if.Prescale   = ps;
        tx_if.DATA_VALID = 1'b1;
        if (track) begin
            e.data = d;
            e.pen  = pen;
            e.ptyp = typ;
            e.p    = (ps < 6'd2) ? 2 : int'(ps);
            e.k    = cyc + 1;
            sb_q.push_back(e);
        end
        @(negedge CLK);
        tx_if.DATA_VALID = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", sb_q.size() + int'(mon_busy), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        exp_t e;
        int   k1;
        tx_if.P_DATA     = '0;
        tx_if.DATA_VALID = 1'b0;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.Prescale   = 6'd8;

        #1 RST = 1'b0;
        #2;
        chk("rst_tx", tx_if.TX_OUT, 1'b1);
        chk("rst_busy", tx_if.Busy, 1'b0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge CLK);

        // Plain frame, then the three parity cases.
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b1);
        wait_done(200);
        send(8'h07, 1'b1, PAR_EVEN, 6'd4, 1'b1);
        wait_done(200);
        send(8'h07, 1'b1, PAR_ODD, 6'd4, 1'b1);
        wait_done(200);
        send(8'hA5, 1'b1, PAR_EVEN, 6'd4, 1'b1);
        wait_done(200);

        // A strobe while busy must be dropped and must not disturb the frame.
        send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b1);
        repeat (18) @(negedge CLK);
        tx_if.P_DATA     = 8'h3C;
        tx_if.PAR_EN     = 1'b1;
        tx_if.DATA_VALID = 1'b1;
        @(negedge CLK);
        tx_if.DATA_VALID = 1'b0;
        wait_done(200);
        repeat (100) @(negedge CLK);

        // Held DATA_VALID: second frame accepted exactly N*P+1 edges after the first.
        @(negedge CLK);
        tx_if.P_DATA     = 8'h55;
        tx_if.PAR_EN     = 1'b0;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.Prescale   = 6'd4;
        tx_if.DATA_VALID = 1'b1;
        k1 = cyc + 1;
        e.data = 8'h55; e.pen = 1'b0; e.ptyp = 1'b0; e.p = 4; e.k = k1;
        sb_q.push_back(e);
        e.data = 8'hAA; e.k = k1 + 41;
        sb_q.push_back(e);
        repeat (5) @(negedge CLK);
        tx_if.P_DATA = 8'hAA;
        for (int i = 0; i < 100 && cyc < k1 + 41; i++) @(negedge CLK);
        tx_if.DATA_VALID = 1'b0;
        wait_done(200);

        // Prescale clamp, odd prescale, and mid-frame prescale change.
        send(8'h3C, 1'b0, 1'b0, 6'd0, 1'b1);
        wait_done(200);
        send(8'h96, 1'b1, PAR_ODD, 6'd5, 1'b1);
        wait_done(200);
        send(8'h5A, 1'b1, PAR_EVEN, 6'd6, 1'b1);
        repeat (10) @(negedge CLK);
        tx_if.Prescale = 6'd3;
        wait_done(200);

        // Asynchronous abort during data bit 3, then a clean frame.
        repeat (2) @(negedge CLK);
        mon_en = 1'b0;
        send(8'h00, 1'b0, 1'b0, 6'd8, 1'b0);
        repeat (35) @(negedge CLK);
        chk("pre_rst_tx", tx_if.TX_OUT, 1'b0);
        chk("pre_rst_busy", tx_if.Busy, 1'b1);
        #2 RST = 1'b0;
        #1;
        chk("abort_tx", tx_if.TX_OUT, 1'b1);
        chk("abort_busy", tx_if.Busy, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("post_rst_tx", tx_if.TX_OUT, 1'b1);
        mon_en = 1'b1;
        send(8'h81, 1'b0, 1'b0, 6'd8, 1'b1);
        wait_done(200);

        repeat (20) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmitter for the low-power multi-clock system's UART, the transmit-side counterpart of the oversampled receiver. Accepts a parallel byte with a one-cycle valid strobe and serializes it LSB-first as start, data, optional parity and stop bits. Each bit is held for `Prescale` cycles of CLK, so TX and RX share one oversampled UART clock and one prescale setting. Runs entirely in the UART clock domain.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_WIDTH`, 6: width of `Prescale`.
- `CLK`  in  1: UART oversampled clock.
- `RST`  in  1: reset, asynchronous, active-low.
- `P_DATA`  in  DATA_WIDTH: parallel data to send.
- `DATA_VALID`  in  1: strobe; request to send `P_DATA`.
- `PAR_EN`  in  1: 1 = append a parity bit.
- `PAR_TYP`  in  1: 0 = even parity, 1 = odd parity.
- `Prescale`  in  PRESCALE_WIDTH: CLK cycles per bit.
- `TX_OUT`  out  1: serial line, idle high, registered.
- `Busy`  out  1: frame in progress, registered.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP.
- **IDLE:** `TX_OUT`=1 and `Busy`=0. If `DATA_VALID`=1 at a CLK edge, the block latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`, then goes to START.
- **START:** `TX_OUT`=0. Goes to DATA.
- **DATA:** `TX_OUT` = data[bit_idx]. `bit_idx` runs from 0 to DATA_WIDTH-1, so the LSB goes first. After the last bit, the FSM goes to PARITY if the latched `PAR_EN`=1, otherwise to STOP.
- **PARITY:** `TX_OUT` = XOR of all latched data bits, then XOR with `PAR_TYP`. This gives even parity for `PAR_TYP`=0 and odd parity for `PAR_TYP`=1. Goes to STOP.
- **STOP:** `TX_OUT`=1. Goes to IDLE.
- **Bit timing:** `edge_cnt` counts 0 to P-1 within each bit, where P is the latched prescale. The state advances when `edge_cnt`=P-1, and `edge_cnt` then wraps to 0.
- **Prescale values:** latched values of 0 or 1 are clamped to 2. The supported range is 4 to 32 (the receiver's window needs P ≥ 4), and odd values are allowed.
- **Inputs during a frame:** `DATA_VALID` is ignored while `Busy`=1. There is no queueing and no error flag. Changes to `P_DATA`, `PAR_EN`, `PAR_TYP` or `Prescale` mid-frame have no effect, because the values are latched.
- **Reset mid-frame:** the frame is aborted. `TX_OUT` goes to 1 and `Busy` to 0 immediately (asynchronously), and the FSM returns to IDLE with counters cleared.
- **Reset values:** `TX_OUT`=1, `Busy`=0, state IDLE, `edge_cnt`=0, `bit_idx`=0, data/parity latches 0.

## Timing
- Let N = 10 without parity and 11 with parity (for DATA_WIDTH=8).
- Accept edge k, with `DATA_VALID`=1 in IDLE: after edge k, `TX_OUT`=0 and `Busy`=1. Latency is one cycle, with no combinational path from input to output.
- Bit j (j=0 for the start bit) is driven after edges k+jP through k+(j+1)P-1.
- After edge k+NP: `TX_OUT`=1, `Busy`=0, state IDLE. `DATA_VALID` at edge k+NP is not accepted.
- The earliest next accept is edge k+NP+1. The minimum frame period is NP+1 cycles, which guarantees at least one idle cycle between frames.
- `DATA_VALID` held high continuously produces back-to-back frames at that period, with each frame sending the `P_DATA` present at its own accept edge.
- `Busy` is high for exactly NP cycles per frame.

## Structure
- Shared `uart_pkg` holds:
  - the state encoding typedef (3-bit, shared naming with the RX FSM);
  - `START_BIT`=1'b0 and `STOP_BIT`=1'b1;
  - `PAR_EVEN`=0 and `PAR_ODD`=1;
  - `PRESCALE_MIN`=2;
  - the default widths.
- Sub-module `uart_tx_parity_calc` holds the parity logic: inputs are data and `PAR_TYP`, output is the parity bit. It is computed once from the latched data, and the same module is reusable by the RX parity checker.
- The FSM, `edge_cnt`, `bit_idx` and the output register are all in the top module.

## Test plan
- **No parity:** P=8, `P_DATA`=0xA5, `PAR_EN`=0, one-cycle strobe. `TX_OUT` is 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles. `Busy` is high 80 cycles, then `TX_OUT`=1 and `Busy`=0.
- **Even parity:** P=4, `P_DATA`=0x07, `PAR_EN`=1, `PAR_TYP`=0. The parity bit is 1 and the frame is 44 cycles. With `PAR_TYP`=1 the parity bit is 0. With `P_DATA`=0xA5 and even parity, the parity bit is 0.
- **Busy ignore:** pulse `DATA_VALID` with 0x3C at cycle 20 of a 0xA5 frame (P=8). The 0xA5 frame is unaltered and no second frame is sent.
- **Back-to-back:** `DATA_VALID` held high, `P_DATA`=0x55 then 0xAA, P=4, no parity. The second start bit begins exactly 41 cycles after the first.
- **Reset mid-frame:** assert `RST` low during data bit 3. `TX_OUT`=1 and `Busy`=0 with no clock edge. After release, a new 0x81 frame transmits correctly.
- **Prescale edges:** `Prescale`=0 gives 2-cycle bits. `Prescale`=5 (odd) gives 5-cycle bits. Changing `Prescale` mid-frame leaves the current frame's bit width unchanged.
